// File: rtl/even_leds_axil_slave.sv
`timescale 1ns/1ps
// AXI4-Lite slave: four 32-bit registers driving even-indexed LEDs with optional blinking.
// Define EVEN_LEDS_WSTRB_EN to honour WSTRB byte lanes on register writes.
module even_leds_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_LEDS           = 8
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [NUM_LEDS-1:0]             LEDS
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam logic [1:0] SEL_PERIOD = 2'd2;

    typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    function automatic logic [NUM_LEDS-1:0] even_mask();
        logic [NUM_LEDS-1:0] m;
        m = {NUM_LEDS{1'b0}};
        for (int i = 0; i < NUM_LEDS; i += 2) m[i] = 1'b1;
        return m;
    endfunction

    localparam logic [NUM_LEDS-1:0] EVEN_MASK = even_mask();

`ifdef EVEN_LEDS_WSTRB_EN
    function automatic logic [DW-1:0] merge_strb(input logic [DW-1:0] old_v,
                                                 input logic [DW-1:0] new_v,
                                                 input logic [DW/8-1:0] strb);
        logic [DW-1:0] r;
        r = old_v;
        for (int i = 0; i < DW/8; i++) if (strb[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
        return r;
    endfunction
`endif

    w_state_t            w_state_r, w_state_nxt_s;
    r_state_t            r_state_r, r_state_nxt_s;
    logic                aw_done_r, w_done_r, aw_done_nxt_s, w_done_nxt_s;
    logic [1:0]          awsel_r;
    logic [DW-1:0]       wdata_r;
    logic                awready_r, wready_r, bvalid_r, arready_r, rvalid_r;
    logic                awready_nxt_s, wready_nxt_s, bvalid_nxt_s, arready_nxt_s, rvalid_nxt_s;
    logic [DW-1:0]       rdata_r;
    logic [DW-1:0]       regs_r [4];
    logic [DW-1:0]       blink_cnt_r;
    logic                phase_r;
    logic [NUM_LEDS-1:0] leds_r, leds_nxt_s;
    logic                aw_hs_s, w_hs_s, ar_hs_s, wr_fire_s, period_wr_s;
    logic [1:0]          wr_sel_s;
    logic [DW-1:0]       wr_data_s, wr_value_s, period_s;
    logic                en_s, blink_en_s;
    logic                unused_s;

    assign aw_hs_s     = S_AXI_AWVALID & awready_r;
    assign w_hs_s      = S_AXI_WVALID & wready_r;
    assign ar_hs_s     = S_AXI_ARVALID & arready_r;
    assign wr_sel_s    = aw_hs_s ? S_AXI_AWADDR[3:2] : awsel_r;
    assign wr_data_s   = w_hs_s ? S_AXI_WDATA : wdata_r;
    assign wr_fire_s   = (w_state_r == W_IDLE) & (aw_done_r | aw_hs_s) & (w_done_r | w_hs_s);
    assign period_wr_s = wr_fire_s & (wr_sel_s == SEL_PERIOD);
    assign en_s        = regs_r[0][0];
    assign blink_en_s  = regs_r[0][1];
    assign period_s    = regs_r[2];

`ifdef EVEN_LEDS_WSTRB_EN
    logic [DW/8-1:0] wstrb_r;
    // Byte strobes travel with the data beat and are held alongside it.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)    wstrb_r <= {(DW/8){1'b0}};
        else if (w_hs_s) wstrb_r <= S_AXI_WSTRB;
    end
    assign wr_value_s = merge_strb(regs_r[wr_sel_s], wr_data_s, w_hs_s ? S_AXI_WSTRB : wstrb_r);
    assign unused_s   = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
`else
    assign wr_value_s = wr_data_s;
    assign unused_s   = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], S_AXI_WSTRB};
`endif

    // Write FSM state register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) w_state_r <= W_IDLE;
        else          w_state_r <= w_state_nxt_s;
    end

    // Write FSM next state.
    always_comb begin
        w_state_nxt_s = w_state_r;
        case (w_state_r)
            W_IDLE:  w_state_nxt_s = wr_fire_s ? W_RESP : W_IDLE;
            W_RESP:  w_state_nxt_s = S_AXI_BREADY ? W_IDLE : W_RESP;
            default: w_state_nxt_s = W_IDLE;
        endcase
    end

    // Write FSM outputs: a channel that handshaked stays latched and its READY drops.
    always_comb begin
        aw_done_nxt_s = 1'b0;
        w_done_nxt_s  = 1'b0;
        if (w_state_nxt_s == W_IDLE && w_state_r == W_IDLE) begin
            aw_done_nxt_s = aw_done_r | aw_hs_s;
            w_done_nxt_s  = w_done_r | w_hs_s;
        end else begin
            aw_done_nxt_s = 1'b0;
            w_done_nxt_s  = 1'b0;
        end
        awready_nxt_s = (w_state_nxt_s == W_IDLE) & ~aw_done_nxt_s;
        wready_nxt_s  = (w_state_nxt_s == W_IDLE) & ~w_done_nxt_s;
        bvalid_nxt_s  = (w_state_nxt_s == W_RESP);
    end

    // Write channel registers and captured address/data.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            awsel_r   <= 2'd0;
            wdata_r   <= {DW{1'b0}};
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
        end else begin
            aw_done_r <= aw_done_nxt_s;
            w_done_r  <= w_done_nxt_s;
            awsel_r   <= wr_sel_s;
            wdata_r   <= wr_data_s;
            awready_r <= awready_nxt_s;
            wready_r  <= wready_nxt_s;
            bvalid_r  <= bvalid_nxt_s;
        end
    end

    // Register file; a same-edge read sees the old value.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < 4; i++) regs_r[i] <= {DW{1'b0}};
        end else if (wr_fire_s) begin
            regs_r[wr_sel_s] <= wr_value_s;
        end
    end

    // Read FSM state register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) r_state_r <= R_IDLE;
        else          r_state_r <= r_state_nxt_s;
    end

    // Read FSM next state.
    always_comb begin
        r_state_nxt_s = r_state_r;
        case (r_state_r)
            R_IDLE:  r_state_nxt_s = ar_hs_s ? R_DATA : R_IDLE;
            R_DATA:  r_state_nxt_s = S_AXI_RREADY ? R_IDLE : R_DATA;
            default: r_state_nxt_s = R_IDLE;
        endcase
    end

    // Read FSM outputs.
    always_comb begin
        arready_nxt_s = (r_state_nxt_s == R_IDLE);
        rvalid_nxt_s  = (r_state_nxt_s == R_DATA);
    end

    // Read channel registers; RDATA only changes on an AR handshake.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= {DW{1'b0}};
        end else begin
            arready_r <= arready_nxt_s;
            rvalid_r  <= rvalid_nxt_s;
            if (ar_hs_s) rdata_r <= regs_r[S_AXI_ARADDR[3:2]];
        end
    end

    // Blink engine: period counter and phase, cleared by PERIOD writes or when idle.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            blink_cnt_r <= {DW{1'b0}};
            phase_r     <= 1'b0;
        end else if (period_wr_s || !(en_s && blink_en_s)) begin
            blink_cnt_r <= {DW{1'b0}};
            phase_r     <= 1'b0;
        end else if (period_s == {DW{1'b0}}) begin
            blink_cnt_r <= {DW{1'b0}};
            phase_r     <= 1'b1;
        end else if (blink_cnt_r == period_s - {{(DW-1){1'b0}}, 1'b1}) begin
            blink_cnt_r <= {DW{1'b0}};
            phase_r     <= ~phase_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + {{(DW-1){1'b0}}, 1'b1};
        end
    end

    // LED value from current registers and phase; odd lanes never light.
    always_comb begin
        leds_nxt_s = {NUM_LEDS{1'b0}};
        if (en_s) begin
            leds_nxt_s = regs_r[1][NUM_LEDS-1:0] & EVEN_MASK &
                         {NUM_LEDS{blink_en_s ? phase_r : 1'b1}};
        end else begin
            leds_nxt_s = {NUM_LEDS{1'b0}};
        end
    end

    // LED output register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) leds_r <= {NUM_LEDS{1'b0}};
        else          leds_r <= leds_nxt_s;
    end

    assign S_AXI_AWREADY = awready_r;
    assign S_AXI_WREADY  = wready_r;
    assign S_AXI_BVALID  = bvalid_r;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = arready_r;
    assign S_AXI_RVALID  = rvalid_r;
    assign S_AXI_RDATA   = rdata_r;
    assign S_AXI_RRESP   = 2'b00;
    assign LEDS          = leds_r;
endmodule
